audio_preemph: RTL and testbench

AUDIO_PREEMPH -- requirements
Module: audio_preemph

---
 rtl/fm_pkg.sv | 16 +
 rtl/audio_preemph_if.sv | 24 ++
 rtl/serial_mul.sv | 51 +++++
 rtl/audio_preemph.sv | 133 +++++++++++++
 tb/tb_audio_preemph.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared widths, default coefficient and pre-emphasis FSM encoding
package fm_pkg;

    localparam int A_W = 8;
    localparam int C_W = 4;

    // Q2.2 coefficient, so 4 is a gain of 1.0 on the difference term
    localparam logic [C_W-1:0] COEF_DEFAULT = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SAT  = 2'd2
    } pe_state_t;

endpackage

// File: rtl/audio_preemph_if.sv
// rtl/audio_preemph_if.sv - sample, control and result signals of the pre-emphasis filter
interface audio_preemph_if import fm_pkg::*; #(
    parameter int A = A_W,
    parameter int C = C_W
);
    logic signed [A-1:0] audio_in;
    logic                audio_dv;
    logic                pe_ena;
    logic [C-1:0]        pe_coef;
    logic signed [A-1:0] audio_out;
    logic                out_dv;
    logic                clip;
    logic                ovr;

    modport master (
        output audio_in, audio_dv, pe_ena, pe_coef,
        input  audio_out, out_dv, clip, ovr
    );

    modport slave (
        input  audio_in, audio_dv, pe_ena, pe_coef,
        output audio_out, out_dv, clip, ovr
    );
endinterface

// File: rtl/serial_mul.sv
// rtl/serial_mul.sv - LSB-first shift-add multiplier, signed multiplicand by unsigned multiplier
module serial_mul import fm_pkg::*; #(
    parameter int DW = A_W + 1,
    parameter int MW = C_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [DW-1:0]    mcand,
    input  logic [MW-1:0]           mplier,
    output logic                    done,
    output logic signed [DW+MW-1:0] product
);
    localparam int PW = DW + MW;
    localparam int CW = (MW > 1) ? $clog2(MW) : 1;

    logic signed [PW-1:0] mcand_sh;
    logic [MW-1:0]        mplier_sh;
    logic [CW-1:0]        cnt;
    logic                 busy;

    // done marks the cycle whose edge adds the last partial product
    assign done = busy && (cnt == CW'(MW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product   <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            product   <= '0;
            mcand_sh  <= {{MW{mcand[DW-1]}}, mcand};
            mplier_sh <= mplier;
            cnt       <= '0;
            busy      <= 1'b1;
        end else if (busy) begin
            if (mplier_sh[0]) begin
                product <= product + mcand_sh;
            end
            mcand_sh  <= mcand_sh <<< 1;
            mplier_sh <= mplier_sh >> 1;
            cnt       <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_preemph.sv
// rtl/audio_preemph.sv - first-order audio pre-emphasis y = sat(x + ((x - x_prev) * g) >>> 2)
module audio_preemph import fm_pkg::*; #(
    parameter int A = A_W,
    parameter int C = C_W
) (
    input  logic            clk,
    input  logic            rst_n,
    audio_preemph_if.slave  bus
);
    localparam int DW = A + 1;
    localparam int PW = A + C + 1;
    localparam int SW = A + C + 2;

    pe_state_t state, state_nx;

    logic signed [A-1:0]  x_reg;
    logic signed [A-1:0]  x_prev;
    logic signed [A-1:0]  pend_data;
    logic                 pend_valid;

    logic                 take;
    logic signed [A-1:0]  take_x;
    logic [C-1:0]         take_coef;
    logic signed [DW-1:0] take_d;

    logic                 mul_done;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] prod_q;
    logic signed [SW-1:0] y_full;
    logic signed [A-1:0]  y_sat;
    logic                 y_clip;

    logic signed [A-1:0]  audio_out_r;
    logic                 out_dv_r;
    logic                 clip_r;
    logic                 ovr_r;

    assign bus.audio_out = audio_out_r;
    assign bus.out_dv    = out_dv_r;
    assign bus.clip      = clip_r;
    assign bus.ovr       = ovr_r;

    // A waiting sample always wins over a fresh strobe in the same cycle
    assign take_x    = pend_valid ? pend_data : bus.audio_in;
    assign take_coef = bus.pe_ena ? bus.pe_coef : '0;
    assign take_d    = {take_x[A-1], take_x} - {x_prev[A-1], x_prev};

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid || bus.audio_dv) begin
                    take     = 1'b1;
                    state_nx = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nx = ST_SAT;
                end
            end
            ST_SAT:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    serial_mul #(
        .DW (DW),
        .MW (C)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (take),
        .mcand   (take_d),
        .mplier  (take_coef),
        .done    (mul_done),
        .product (product)
    );

    // Arithmetic shift floors negative products, e.g. -3/4 becomes -1
    assign prod_q = product >>> 2;
    assign y_full = {{(SW-A){x_reg[A-1]}}, x_reg} + {{(SW-PW){prod_q[PW-1]}}, prod_q};

    always_comb begin
        y_clip = 1'b0;
        y_sat  = y_full[A-1:0];
        if (y_full[SW-1:A-1] != {(SW-A+1){y_full[SW-1]}}) begin
            y_clip = 1'b1;
            y_sat  = y_full[SW-1] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            x_reg       <= '0;
            x_prev      <= '0;
            pend_data   <= '0;
            pend_valid  <= 1'b0;
            audio_out_r <= '0;
            out_dv_r    <= 1'b0;
            clip_r      <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            state    <= state_nx;
            out_dv_r <= 1'b0;
            clip_r   <= 1'b0;
            if (take) begin
                x_reg <= take_x;
            end
            if (state == ST_SAT) begin
                audio_out_r <= y_sat;
                clip_r      <= y_clip;
                out_dv_r    <= 1'b1;
                x_prev      <= x_reg;
            end
            if (take && pend_valid) begin
                pend_valid <= bus.audio_dv;
                if (bus.audio_dv) begin
                    pend_data <= bus.audio_in;
                end
            end else if (!take && bus.audio_dv) begin
                if (pend_valid) begin
                    ovr_r <= 1'b1;
                end
                pend_valid <= 1'b1;
                pend_data  <= bus.audio_in;
            end
        end
    end

endmodule

// File: tb/tb_audio_preemph.sv
// tb/tb_audio_preemph.sv - directed bench for audio_preemph with a cycle-scheduled reference model
module tb_audio_preemph;
    import fm_pkg::*;

    localparam int A = A_W;
    localparam int C = C_W;
    localparam int Y_HI = (1 << (A - 1)) - 1;
    localparam int Y_LO = -(1 << (A - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_preemph_if #(.A(A), .C(C)) bus ();

    audio_preemph #(.A(A), .C(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    typedef struct {
        int edge_n;
        int y;
        int clp;
    } exp_t;

    exp_t expq[$];
    int   cyc          = 0;
    int   m_busy_until = 0;
    int   m_xprev      = 0;
    bit   m_pend       = 0;
    int   m_pend_x     = 0;
    bit   m_ovr        = 0;
    int   m_held       = 0;
    int   m_x, m_g, m_y, m_c;
    bit   m_took_pend;

    function automatic void ref_y(input int x, input int xp, input int g, output int y, output int c);
        int p, q;
        p = (x - xp) * g;
        q = p / 4;
        if (p < 0 && (p % 4) != 0) q = q - 1;
        y = x + q;
        c = 0;
        if (y > Y_HI) begin y = Y_HI; c = 1; end
        if (y < Y_LO) begin y = Y_LO; c = 1; end
    endfunction

    // Model: an accepted sample appears 5 edges later; the engine is free again 6 edges later
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            expq.delete();
            m_busy_until = 0;
            m_xprev      = 0;
            m_pend       = 0;
            m_ovr        = 0;
            m_held       = 0;
        end else if (cyc >= m_busy_until && (m_pend || bus.audio_dv)) begin
            m_took_pend = m_pend;
            m_x = m_pend ? m_pend_x : int'(bus.audio_in);
            m_g = bus.pe_ena ? int'(bus.pe_coef) : 0;
            ref_y(m_x, m_xprev, m_g, m_y, m_c);
            expq.push_back('{edge_n: cyc + 5, y: m_y, clp: m_c});
            m_xprev      = m_x;
            m_busy_until = cyc + 6;
            if (m_took_pend) begin
                m_pend   = bus.audio_dv;
                m_pend_x = int'(bus.audio_in);
            end
        end else if (bus.audio_dv) begin
            if (m_pend) m_ovr = 1;
            m_pend   = 1;
            m_pend_x = int'(bus.audio_in);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (expq.size() > 0 && expq[0].edge_n == cyc) begin
                check("m_out_dv", int'(bus.out_dv), 1);
                check("m_clip", int'(bus.clip), expq[0].clp);
                m_held = expq[0].y;
                void'(expq.pop_front());
            end else begin
                check("m_out_dv_idle", int'(bus.out_dv), 0);
                check("m_clip_idle", int'(bus.clip), 0);
            end
            check("m_audio_out", int'(bus.audio_out), m_held);
            check("m_ovr", int'(bus.ovr), int'(m_ovr));
        end
    end

    int t_send = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input int x, input bit ena, input int g);
        bus.audio_in = x[A-1:0];
        bus.pe_ena   = ena;
        bus.pe_coef  = g[C-1:0];
        bus.audio_dv = 1'b1;
        tick();
        t_send       = cyc;
        bus.audio_dv = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int exp_y, input int exp_clip);
        int lat;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_dv) begin
                lat = cyc - t_send;
                break;
            end
        end
        check({nm, "_latency"}, lat, 5);
        check({nm, "_y"}, int'(bus.audio_out), exp_y);
        check({nm, "_clip"}, int'(bus.clip), exp_clip);
        tick();
    endtask

    int pulses, first_y, second_y;
    int tp_x[6] = '{100, -90, 60, -128, 127, 0};
    int tp_g[6] = '{15, 3, 7, 2, 15, 4};

    initial begin
        bus.audio_in = '0;
        bus.audio_dv = 1'b0;
        bus.pe_ena   = 1'b1;
        bus.pe_coef  = COEF_DEFAULT;

        do_reset();
        check("rst_audio_out", int'(bus.audio_out), 0);
        check("rst_out_dv", int'(bus.out_dv), 0);
        check("rst_clip", int'(bus.clip), 0);
        check("rst_ovr", int'(bus.ovr), 0);

        send(20, 1, COEF_DEFAULT);
        wait_out("unity_gain", 40, 0);

        do_reset();
        send(-100, 1, 4);
        wait_out("sat_low", -128, 1);
        send(100, 1, 4);
        wait_out("sat_high", 127, 1);

        send(50, 0, 15);
        wait_out("bypass", 50, 0);

        do_reset();
        send(-3, 1, 1);
        wait_out("floor_shift", -4, 0);

        do_reset();
        bus.pe_ena  = 1'b1;
        bus.pe_coef = 4'd4;
        bus.audio_dv = 1'b1;
        bus.audio_in = 8'sd10;
        tick();
        bus.audio_in = 8'sd20;
        tick();
        bus.audio_in = 8'sd30;
        tick();
        bus.audio_dv = 1'b0;
        pulses = 0; first_y = 0; second_y = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.out_dv) begin
                pulses++;
                if (pulses == 1) first_y = int'(bus.audio_out);
                if (pulses == 2) second_y = int'(bus.audio_out);
            end
        end
        check("ovr_pulses", pulses, 2);
        check("ovr_first_y", first_y, 20);
        check("ovr_third_y", second_y, 50);
        check("ovr_flag", int'(bus.ovr), 1);
        tick();

        do_reset();
        send(77, 1, 4);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_dv) pulses++;
        end
        check("inflight_no_dv", pulses, 0);
        check("inflight_audio_out", int'(bus.audio_out), 0);
        check("inflight_ovr", int'(bus.ovr), 0);
        tick();
        send(10, 1, 4);
        wait_out("after_reset", 20, 0);

        for (int i = 0; i < 6; i++) begin
            send(tp_x[i], 1, tp_g[i]);
            for (int k = 0; k < 5; k++) tick();
        end
        for (int k = 0; k < 8; k++) tick();
        check("throughput_ovr", int'(bus.ovr), 0);
        check("throughput_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
